hazard_ctrl: RTL

//   Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC of the pipelined CPU.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/hazard_detect.sv | 16 +
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard FSM state encoding, register-address width,
// and the ALU-op and control-bundle types carried by the pipeline registers.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WAIT_W     = 16;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    branch;
        alu_op_t alu_op;
    } ctrl_bundle_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: the EX-stage load writes a register
// that the ID-stage instruction reads. x0 never creates a hazard.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  mem_read,
    output logic                  hazard
);

    assign hazard = mem_read && (rd_addr != '0) &&
                    ((rd_addr == rs_addr) || (rd_addr == rt_addr));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use bubble, branch flush, and freeze while a
// data-memory access waits for its ack. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] IFID_RSaddr_i,
    input  logic [REG_ADDR_W-1:0] IFID_RTaddr_i,
    input  logic [REG_ADDR_W-1:0] IDEX_RDaddr_i,
    input  logic                  IDEX_MemRead_i,
    input  logic                  Branch_taken_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ack_i,
    output logic                  PCWrite_o,
    output logic                  IFID_Write_o,
    output logic                  IFID_Flush_o,
    output logic                  IDEX_Bubble_o,
    output logic                  EXMEM_Write_o,
    output logic                  MEMWB_Write_o,
    output logic                  state_o,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic [CNT_W-1:0]      memwait_cnt_o,
`endif
    output logic                  memerr_o
);

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              memerr_q;
    logic              hazard;
    logic              freeze;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v >= TIMEOUT_V) ? v : v + 1'b1;
    endfunction

    hazard_detect u_detect (
        .rs_addr  (IFID_RSaddr_i),
        .rt_addr  (IFID_RTaddr_i),
        .rd_addr  (IDEX_RDaddr_i),
        .mem_read (IDEX_MemRead_i),
        .hazard   (hazard)
    );

    // An ack always releases the freeze in the same cycle it arrives.
    assign freeze = (state_q == ST_MEM_WAIT) ? !dmem_ack_i : (dmem_req_i && !dmem_ack_i);

    always_comb begin
        state_d       = state_q;
        PCWrite_o     = 1'b1;
        IFID_Write_o  = 1'b1;
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;
        EXMEM_Write_o = 1'b1;
        MEMWB_Write_o = 1'b1;

        if (freeze) begin
            PCWrite_o     = 1'b0;
            IFID_Write_o  = 1'b0;
            EXMEM_Write_o = 1'b0;
            MEMWB_Write_o = 1'b0;
        end else if (hazard) begin
            PCWrite_o     = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else if (Branch_taken_i) begin
            IFID_Flush_o  = 1'b1;
        end

        if (state_q == ST_RUN && dmem_req_i && !dmem_ack_i) begin
            state_d = ST_MEM_WAIT;
        end else if (state_q == ST_MEM_WAIT && dmem_ack_i) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            memerr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_RUN) begin
                wait_cnt_q <= (state_d == ST_MEM_WAIT) ? WAIT_W'(1) : '0;
            end else if (dmem_ack_i) begin
                wait_cnt_q <= '0;
            end else begin
                wait_cnt_q <= sat_inc(wait_cnt_q);
                if (wait_cnt_q == TIMEOUT_V) begin
                    memerr_q <= 1'b1;
                end
            end
        end
    end

    assign state_o  = (state_q == ST_MEM_WAIT);
    assign memerr_o = memerr_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_q   + CNT_W'(IDEX_Bubble_o);
            flush_cnt_q   <= flush_cnt_q   + CNT_W'(IFID_Flush_o);
            memwait_cnt_q <= memwait_cnt_q + CNT_W'(state_o);
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign memwait_cnt_o = memwait_cnt_q;
`endif

endmodule
